apb_slave_fifo: RTL
===================

// Module: apb_slave_fifo
// PURPOSE
//  APB3 completer for the interconnect: the responder for the APB master's write bursts.
//  Accepts APB transfers, decodes a 3-register map, and buffers DATA writes in a FIFO.
//  The FIFO drains to an IP sink through a valid/ready handshake.
//  Inserts wait states (pready low) when the FIFO is full; flags errors with pslverr.
// PARAMETERS
//  ADDR_WIDTH  8       APB address width
//  DATA_WIDTH  32      APB/IP data width (>=16)
//  FIFO_DEPTH  4       write FIFO entries; power of 2, 2..128
//  BASE_ADDR   0       address of DATA register; STATUS = BASE+4, CTRL = BASE+8
// PORTS
//  pclk     in   1           APB clock; all logic on its rising edge
//  reset    in   1           asynchronous, active-high reset
//  psel     in   1           APB select
//  penable  in   1           APB access phase
//  pwrite   in   1           1 = write, 0 = read
//  paddr    in   ADDR_WIDTH  APB address
//  pwdata   in   DATA_WIDTH  APB write data
//  prdata   out  DATA_WIDTH  APB read data
//  pready   out  1           transfer completes when psel&penable&pready
//  pslverr  out  1           error response, valid only while pready=1
//  ip_din   out  DATA_WIDTH  FIFO head data to the IP sink
//  ip_valid out  1           FIFO not empty
//  ip_ready in   1           sink accepts ip_din (pops) when ip_valid&ip_ready
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE, FIFO empty, CTRL.en=0; prdata=0, pready=0, pslverr=0, ip_valid=0.
//  FSM states IDLE -> SETUP (psel&!penable) -> ACCESS (psel&penable) -> completion.
//   At completion: SETUP if psel&!penable next, otherwise IDLE.
//   ACCESS holds while pready=0. psel low in any state -> IDLE; an abandoned transfer has no side effect.
//   penable without a prior SETUP is ignored (stay IDLE).
//  Register map:
//   DATA   (BASE+0, WO) write pushes pwdata
//   STATUS (BASE+4, RO) [0]=empty, [1]=full, [15:8]=count, rest 0
//   CTRL   (BASE+8, RW) [0]=en, rest 0
//  prdata is registered at SETUP->ACCESS and holds for the access phase; 0 for writes and errors.
//  pready is combinational and only high in ACCESS. It is 1 except on a valid DATA write while full.
//   While full, pready=0 until the cycle after a pop frees a slot.
//  pslverr=1 with pready=1 for:
//   - an unmapped address
//   - a DATA read
//   - a STATUS write
//   - a DATA write while CTRL.en=0
//   An error write has no effect.
//  The push happens on the completing edge. The pop happens on any edge with ip_valid&ip_ready.
//   Push and pop on the same edge: count unchanged, order kept.
//   Push is never attempted while full, so there is no overflow.
//  ip_din = FIFO head, ip_valid = !empty. Data is presented in write order.
//   Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
//  CTRL.en=0 does not stop draining; already buffered data still pops.
//  Reset mid-transfer: pready and ip_valid drop immediately, FIFO contents are lost.
// TESTING
//  1 Reset, read STATUS(0x04) -> prdata=0x00000001, pready=1 in first ACCESS cycle, pslverr=0.
//  2 Write CTRL=1, write DATA=0xA5A50001 with ip_ready=0 -> ip_valid=1, ip_din=0xA5A50001;
//    STATUS read=0x00000100.
//  3 Four DATA writes 1..4 (ip_ready=0), fifth write=5 -> pready low.
//    Raise ip_ready after 3 cycles -> pready high the next cycle.
//    Sink sees 1,2,3,4,5 in order.
//  4 CTRL=0, write DATA -> pslverr=1, no push; read 0x0C -> pslverr=1, prdata=0.
//  5 Count=2, pop and complete a DATA write on the same edge -> STATUS count=2, order preserved.
//  6 Assert reset during a full-FIFO wait state -> pready=0, ip_valid=0 immediately;
//    STATUS after reset=0x00000001.

Source files
------------

// File: rtl/apb_slave_fifo.sv
// apb_slave_fifo: APB3 completer that buffers DATA register writes in a FIFO drained by a valid/ready sink
module apb_slave_fifo #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] ip_din,
    output logic                  ip_valid,
    input  logic                  ip_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(BASE_ADDR + 4);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(BASE_ADDR + 8);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           count;
    logic                  en, empty, full, access, is_data, is_stat, is_ctrl, err, push, pop;
    logic [DATA_WIDTH-1:0] status, rd_val;

    // decode, handshake outputs and next state; SETUP/ACCESS record that the previous cycle opened or stalled a transfer
    always_comb begin
        empty    = count == '0;
        full     = count == (AW+1)'(FIFO_DEPTH);
        is_data  = paddr == A_DATA;
        is_stat  = paddr == A_STAT;
        is_ctrl  = paddr == A_CTRL;
        access   = psel && penable && state_q != IDLE;
        err      = !(is_data || is_stat || is_ctrl) || (is_data && (!pwrite || !en)) || (is_stat && pwrite);
        pready   = access && !(is_data && pwrite && en && full);
        pslverr  = pready && err;
        push     = pready && pwrite && is_data && en;
        pop      = !empty && ip_ready;
        ip_valid = !empty;
        ip_din   = mem[rptr];
        status   = DATA_WIDTH'({8'(count), 6'b0, full, empty});
        rd_val   = pwrite ? '0 : is_stat ? status : is_ctrl ? DATA_WIDTH'(en) : '0;
        state_d  = !psel ? IDLE : !penable ? SETUP : (access && !pready) ? ACCESS : IDLE;
    end

    // FSM state and read data captured at the end of the setup phase
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            if (psel && !penable) prdata <= rd_val;
        end
    end

    // FIFO pointers, occupancy and CTRL.en
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            en    <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pready && pwrite && is_ctrl) en <= pwdata[0];
        end
    end

    // FIFO storage; contents are meaningless once count is cleared
    always_ff @(posedge pclk) begin
        if (push) mem[wptr] <= pwdata;
    end
endmodule
